// File: rtl/servo_pkg.sv
// Shared types and constants for the joystick-driven servo PWM blocks.
package servo_pkg;

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } servo_state_t;

    localparam logic [9:0] JSTK_CENTER = 10'd512;
    localparam logic [9:0] JSTK_MAX    = 10'd1023;
    localparam int         PULSE_W     = 12;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler: one-cycle us_tick every CLK_FREQ_HZ/1e6 clocks.
module us_tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic us_tick
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap  = (r_cnt == W'(DIV - 1));
    assign us_tick = w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jstk_servo_pwm.sv
// Joystick X sample -> 50 Hz hobby-servo PWM with deadzone and bumper centre.
// Optional per-frame slew limiting is enabled by SERVO_SLEW_LIMIT_EN.
module jstk_servo_pwm
    import servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000,
    parameter int DEADZONE     = 16,
    parameter int SLEW_STEP_US = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        x_val,
    input  logic               x_bumper,
    output logic               pwm_out,
    output logic [PULSE_W-1:0] pulse_us,
    output logic               frame_start
);

    localparam int CNT_W = $clog2(PERIOD_US);
    localparam int SPAN  = MAX_PULSE_US - MIN_PULSE_US;
    localparam logic [PULSE_W-1:0] CENTER_US =
        PULSE_W'((MIN_PULSE_US + MAX_PULSE_US) / 2);

    logic               w_us_tick;
    logic               w_bound;
    logic               w_pulse_end;
    logic [CNT_W-1:0]   r_us_cnt;
    servo_state_t       r_state;
    servo_state_t       w_state_nxt;
    logic [PULSE_W-1:0] r_pulse;
    logic [PULSE_W-1:0] w_target;
    logic [PULSE_W-1:0] w_pulse_nxt;
    logic               r_frame_start;
    logic [9:0]         w_xc;
    logic [9:0]         w_dist;
    logic [9:0]         w_xm;

    us_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .us_tick (w_us_tick)
    );

    assign w_bound     = w_us_tick && (r_us_cnt == CNT_W'(PERIOD_US - 1));
    assign w_pulse_end = w_us_tick &&
                         ((32'(r_us_cnt) + 32'd1) == 32'(r_pulse));

    // Bit 10 clamps to full scale; deadzone and bumper snap to centre.
    always_comb begin
        w_xc   = x_val[10] ? JSTK_MAX : x_val[9:0];
        w_dist = (w_xc >= JSTK_CENTER) ? (w_xc - JSTK_CENTER)
                                       : (JSTK_CENTER - w_xc);
        w_xm   = w_xc;
        if (x_bumper || (32'(w_dist) < 32'(DEADZONE))) begin
            w_xm = JSTK_CENTER;
        end
        w_target = PULSE_W'(32'(MIN_PULSE_US) +
                            ((32'(w_xm) * 32'(SPAN)) >> 10));
    end

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [PULSE_W-1:0] STEP = PULSE_W'(SLEW_STEP_US);

    always_comb begin
        w_pulse_nxt = w_target;
        if (w_target > r_pulse + STEP) begin
            w_pulse_nxt = r_pulse + STEP;
        end else if (w_target + STEP < r_pulse) begin
            w_pulse_nxt = r_pulse - STEP;
        end
    end
`else
    assign w_pulse_nxt = w_target;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_LOW:   if (w_bound)     w_state_nxt = S_HIGH;
            S_HIGH:  if (w_pulse_end) w_state_nxt = S_LOW;
            default: w_state_nxt = S_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_us_cnt      <= CNT_W'(PERIOD_US - 1);
            r_pulse       <= CENTER_US;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_bound;
            if (w_us_tick) begin
                r_us_cnt <= w_bound ? '0 : r_us_cnt + 1'b1;
            end
            if (w_bound) begin
                r_pulse <= w_pulse_nxt;
            end
        end
    end

    assign pwm_out     = (r_state == S_HIGH);
    assign pulse_us    = r_pulse;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_jstk_servo_pwm.sv
// Self-checking bench for jstk_servo_pwm: frame-level measurement vs a reference model.
module tb_jstk_servo_pwm;

    localparam int CLK_HZ = 2_000_000;
    localparam int CPU    = CLK_HZ / 1_000_000;
    localparam int PER    = 2010;
    localparam int PMIN   = 1000;
    localparam int PMAX   = 2000;
    localparam int DZ     = 16;
    localparam int SLEW   = 20;
    localparam int LIM    = 2 * PER * CPU + 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] x_val = '0;
    logic        x_bumper = 1'b0;
    logic        pwm_out;
    logic [11:0] pulse_us;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] x;
        logic        b;
        int          exp;
    } vec_t;

    vec_t tbl[8];

    jstk_servo_pwm #(
        .CLK_FREQ_HZ (CLK_HZ),
        .PERIOD_US   (PER),
        .MIN_PULSE_US(PMIN),
        .MAX_PULSE_US(PMAX),
        .DEADZONE    (DZ),
        .SLEW_STEP_US(SLEW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_val      (x_val),
        .x_bumper   (x_bumper),
        .pwm_out    (pwm_out),
        .pulse_us   (pulse_us),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse width in us the servo should show for a sample, given the previous pulse.
    function automatic int model(input int x, input bit b, input int prev);
        int xc;
        int tgt;
        xc = (x > 1023) ? 1023 : x;
        if (b || ((xc - 512 < DZ) && (512 - xc < DZ))) xc = 512;
        tgt = PMIN + (xc * (PMAX - PMIN)) / 1024;
`ifdef SERVO_SLEW_LIMIT_EN
        if (tgt > prev + SLEW) tgt = prev + SLEW;
        else if (tgt < prev - SLEW) tgt = prev - SLEW;
`else
        if (prev < 0) tgt = 0;
`endif
        return tgt;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one sample after a frame_start; measures that frame up to the next one.
    task automatic frame(input logic [10:0] sx, input logic sb,
                         input logic [10:0] mx, input logic mb,
                         input int exp, input string tag);
        int hi;
        int n;
        bit done;
        hi = 0;
        n = 0;
        done = 0;
        check({tag, " pulse_us"}, int'(pulse_us), exp);
        x_val = sx;
        x_bumper = sb;
        while (!done && n < LIM) begin
            if (pwm_out) hi++;
            step();
            n++;
            if (n == 100) begin
                x_val = mx;
                x_bumper = mb;
            end
            if (frame_start) done = 1;
        end
        check({tag, " high_cycles"}, hi, exp * CPU);
        check({tag, " period_cycles"}, n, PER * CPU);
    endtask

    task automatic release_and_sync(input string tag);
        rst = 1'b0;
        step();
        check({tag, " fs_cycle1"}, int'(frame_start), 0);
        step();
        check({tag, " fs_cycle2"}, int'(frame_start), 1);
        check({tag, " pwm_cycle2"}, int'(pwm_out), 1);
    endtask

    initial begin
        int cur;
        int rx;
        bit rb;

        tbl[0] = '{11'd0,    1'b0, 1000};
        tbl[1] = '{11'd1023, 1'b0, 1999};
        tbl[2] = '{11'h7FF,  1'b0, 1999};
        tbl[3] = '{11'd520,  1'b0, 1500};
        tbl[4] = '{11'd528,  1'b0, 1515};
        tbl[5] = '{11'd1023, 1'b1, 1500};
        tbl[6] = '{11'd496,  1'b0, 1484};
        tbl[7] = '{11'd497,  1'b0, 1500};

        rst = 1'b1;
        x_val = 11'd0;
        x_bumper = 1'b0;
        repeat (3) step();
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset pulse_us", int'(pulse_us), 1500);
        check("reset frame_start", int'(frame_start), 0);
        release_and_sync("first boundary");
        cur = model(0, 0, 1500);

        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].x, tbl[i].b, tbl[i].x, tbl[i].b, cur,
                  $sformatf("vec%0d", i));
`ifdef SERVO_SLEW_LIMIT_EN
            cur = model(int'(tbl[i].x), tbl[i].b, cur);
`else
            cur = tbl[i].exp;
`endif
        end

        frame(11'd1023, 1'b0, 11'd1023, 1'b0, cur, "pre-mid");
        cur = model(1023, 0, cur);
        frame(11'd1023, 1'b0, 11'd0, 1'b0, cur, "mid-change");
        cur = model(0, 0, cur);

        for (int i = 0; i < 5; i++) begin
            rx = $urandom_range(0, 2047);
            rb = ($urandom_range(0, 3) == 0);
            frame(11'(rx), rb, 11'(rx), rb, cur, $sformatf("rand%0d", i));
            cur = model(rx, rb, cur);
        end

        check("pre-reset pulse_us", int'(pulse_us), cur);
        x_val = 11'd0;
        x_bumper = 1'b0;
        repeat (100) step();
        check("pre-reset pwm high", int'(pwm_out), 1);
        rst = 1'b1;
        step();
        check("midpulse rst pwm_out", int'(pwm_out), 0);
        check("midpulse rst pulse_us", int'(pulse_us), 1500);
        check("midpulse rst frame_start", int'(frame_start), 0);
        repeat (3) step();
        x_val = 11'd1023;
        release_and_sync("post-reset boundary");
        cur = model(1023, 0, 1500);
        frame(11'd1023, 1'b0, 11'd1023, 1'b0, cur, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
